matlu_solve: RTL and testbench
==============================

Name: matlu_solve

Overview:
- Solves A·x = b using the packed LU factorisation and permutation vector produced by the matlu stage. Uses forward substitution on the unit-lower L, then back substitution on U.
- Sits directly downstream of matlu. Its lu, p and singular outputs are wired to this block, together with a right-hand-side vector b.
- Uses one time-shared signed fixed-point MAC and one iterative divider, so the area stays flat as MATRIX_SIZE grows.

Parameters:
- DATA_WIDTH, 32, width of every fixed-point element, two's complement.
- BIN_POS, 16, number of fractional bits.
- MATRIX_SIZE, 3, N; the matrix is N×N and the vectors have N entries.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low. rst=0 forces the reset state immediately.
- start  in  1  request to begin a solve; accepted only when ready=1.
- ready  out  1  high when the block can accept start (IDLE or DONE).
- complete  out  1  high when x/solve_singular are valid; held until the next accepted start.
- lu  in  N*N*DATA_WIDTH  packed LU. Element (r,c) is at [(r*N+c)*DATA_WIDTH +: DATA_WIDTH]. Strictly-lower part is L (diagonal implied 1); upper part including the diagonal is U.
- p  in  (N+1)*DATA_WIDTH  p[i] = index of the source row of b for row i, for i<N. p[N] = swap count, which this block ignores.
- lu_singular  in  1  singular flag from matlu.
- b  in  N*DATA_WIDTH  right-hand side; element i is at [i*DATA_WIDTH +: DATA_WIDTH].
- x  out  N*DATA_WIDTH  solution vector, same packing as b.
- solve_singular  out  1  set if lu_singular was set at start, or if any U[i][i]==0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ready=1, complete=0, x=0, solve_singular=0.
  - All internal registers clear; any in-flight solve is abandoned.
- Acceptance:
  - start is accepted on a rising edge where start=1 and ready=1.
  - On that edge, lu, p, b and lu_singular are copied into internal registers, so upstream may change them afterwards.
  - complete and ready drop on the same edge, and solve_singular clears.
  - start while busy is ignored.
- States:
  - IDLE: ready=1. On accept → LOAD.
  - LOAD (1 cycle):
    - If lu_singular: x=0, solve_singular=1 → DONE.
    - Otherwise y[i]=b[p[i]] for all i, then → FWD. A p[i] ≥ N maps to b[0].
  - FWD: for rows i=0..N-1:
    - i MAC cycles accumulate acc += L[i][j]*y[j] for j<i.
    - Then 1 write cycle: y[i] = y[i] − trunc(acc).
  - BWD: for rows i=N-1..0:
    - N−1−i MAC cycles accumulate acc += U[i][j]*x[j] for j>i.
    - Then D = DATA_WIDTH+BIN_POS divide cycles compute x[i] = ((y[i] − trunc(acc)) <<< BIN_POS) / U[i][i].
    - Then 1 write cycle.
    - If U[i][i]==0, detected at the start of the row: x=0, solve_singular=1 → DONE immediately.
  - DONE: complete=1, ready=1, outputs frozen. On accept → LOAD.
- Arithmetic:
  - Products are signed 2·DATA_WIDTH wide and accumulate in a 2·DATA_WIDTH+clog2(N) accumulator.
  - trunc(acc) = acc >>> BIN_POS (arithmetic shift), keeping the low DATA_WIDTH bits.
  - Subtraction wraps modulo 2^DATA_WIDTH; there is no saturation.
  - Division is signed restoring division, truncating toward zero; the quotient keeps the low DATA_WIDTH bits.
- Latency:
  - Accept edge to complete high for a non-singular solve = 1 + N(N+1) + N·D cycles.
  - Singular via lu_singular = 1 cycle.
  - Singular via a zero pivot completes in the cycle after that row's pivot is checked.
- x is updated only on entry to DONE; intermediate values are never visible on x.

Test Plan:
- Reset → ready=1, complete=0, x=0, solve_singular=0. Drive rst=0 mid-BWD → same values asynchronously, before the next clock edge.
- Identity case (W=32, B=16, N=3): lu = identity (diagonal 0x00010000), p=[0,1,2,0], b=[0x00010000, 0x00020000, 0xFFFF0000] → x=b, solve_singular=0, complete at exactly 1+12+144=157 cycles after accept.
- Pivoted case (N=2, A=[[2,1],[4,3]], b=[3,7]):
  - Inputs: lu=[0x00040000, 0x00030000, 0x00008000, 0xFFFF8000], p=[1,0,0].
  - Expected: x=[0x00010000, 0x00010000], complete after 103 cycles.
- Zero pivot (N=2): lu with U[1][1]=0 → solve_singular=1, x=0, complete=1. Also lu_singular=1 at start → complete 1 cycle after accept, solve_singular=1.
- Start while busy: assert start during FWD with different b → ignored; result equals the first solve's x.
- Back-to-back: start asserted in DONE → accepted, complete drops next edge. Second result is correct and independent of the first.

Source files
------------

// File: rtl/matlu_solve_if.sv
// Bundle carrying the solve handshake, the matlu results and the solution vector.
// The slave side is the solver; the master side is whoever requests a solve.
interface matlu_solve_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int MATRIX_SIZE = 3
);
  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_WIDTH;

  logic                  start;
  logic                  ready;
  logic                  complete;
  logic [N*N*DW-1:0]     lu;
  logic [(N+1)*DW-1:0]   p;
  logic                  lu_singular;
  logic [N*DW-1:0]       b;
  logic [N*DW-1:0]       x;
  logic                  solve_singular;

  modport slave (
    input  start, lu, p, lu_singular, b,
    output ready, complete, x, solve_singular
  );

  modport master (
    output start, lu, p, lu_singular, b,
    input  ready, complete, x, solve_singular
  );
endinterface

// File: rtl/matlu_solve.sv
// Solves A*x = b from a packed LU factorisation and row permutation, using
// one time-shared fixed-point MAC and one bit-serial restoring divider.
module matlu_solve #(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int MATRIX_SIZE = 3
) (
  input  logic          clk,
  input  logic          rst,
  matlu_solve_if.slave  bus
);
  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int BP = BIN_POS;
  localparam int D  = DW + BP;
  localparam int QW = DW + BP;
  localparam int AW = 2*DW + $clog2(N);
  localparam int RW = $clog2(N+1);
  localparam int CW = $clog2(D+1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FWD, S_BWD, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [N*N*DW-1:0]     lu_q, lu_d;
  logic [N*DW-1:0]       p_q, p_d;
  logic [N*DW-1:0]       b_q, b_d;
  logic                  lsing_q, lsing_d;
  logic [N*DW-1:0]       y_q, y_d;
  logic [N*DW-1:0]       xw_q, xw_d;
  logic [N*DW-1:0]       x_q, x_d;
  logic                  sing_q, sing_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [QW-1:0]         q_q, q_d;
  logic [DW-1:0]         r_q, r_d;
  logic [RW-1:0]         row_q, row_d;
  logic [RW-1:0]         col_q, col_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  int                    ri, ci, si;
  logic [DW-1:0]         p_el;
  logic signed [DW-1:0]  mac_a, mac_b, piv, y_row, tr, num;
  logic signed [2*DW-1:0] prod;
  logic [QW-1:0]         dvd, dvd_mag, q_in;
  logic [DW-1:0]         dvs_mag, r_in, quo;
  logic [DW:0]           r_sh;
  logic                  ge, quo_neg, ready, accept;

  // The swap count in the top slot of p is not needed to solve.
  logic unused_swap;
  assign unused_swap = ^bus.p[(N+1)*DW-1:N*DW];

  assign ready              = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept             = bus.start && ready;
  assign bus.ready          = ready;
  assign bus.complete       = (state_q == S_DONE);
  assign bus.x              = x_q;
  assign bus.solve_singular = sing_q;

  always_comb begin : datapath
    ri    = int'(row_q);
    ci    = int'(col_q);
    piv   = lu_q[(ri*N+ri)*DW +: DW];
    y_row = y_q[ri*DW +: DW];
    mac_a = '0;
    mac_b = '0;
    if (ci < N) begin
      mac_a = lu_q[(ri*N+ci)*DW +: DW];
      mac_b = (state_q == S_FWD) ? y_q[ci*DW +: DW] : xw_q[ci*DW +: DW];
    end
    prod    = (2*DW)'(mac_a) * (2*DW)'(mac_b);
    tr      = DW'(acc_q >>> BP);
    num     = y_row - tr;
    // Division runs on magnitudes; the sign is reapplied on the write cycle.
    dvd     = {num, {BP{1'b0}}};
    dvd_mag = num[DW-1] ? (~dvd + 1'b1) : dvd;
    dvs_mag = piv[DW-1] ? (~$unsigned(piv) + 1'b1) : $unsigned(piv);
    quo_neg = num[DW-1] ^ piv[DW-1];
    q_in    = (cnt_q == '0) ? dvd_mag : q_q;
    r_in    = (cnt_q == '0) ? '0 : r_q;
    r_sh    = {r_in, q_in[QW-1]};
    ge      = (r_sh >= {1'b0, dvs_mag});
    quo     = quo_neg ? DW'(~q_q + 1'b1) : q_q[DW-1:0];
  end

  always_comb begin : next_state
    state_d = state_q;
    lu_d    = lu_q;
    p_d     = p_q;
    b_d     = b_q;
    lsing_d = lsing_q;
    y_d     = y_q;
    xw_d    = xw_q;
    x_d     = x_q;
    sing_d  = sing_q;
    acc_d   = acc_q;
    q_d     = q_q;
    r_d     = r_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    p_el    = '0;
    si      = 0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_LOAD;
          lu_d    = bus.lu;
          p_d     = bus.p[N*DW-1:0];
          b_d     = bus.b;
          lsing_d = bus.lu_singular;
          sing_d  = 1'b0;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (lsing_q) begin
          x_d     = '0;
          sing_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          for (int i = 0; i < N; i++) begin
            p_el = p_q[i*DW +: DW];
            si   = (p_el < DW'(N)) ? int'(p_el) : 0;
            y_d[i*DW +: DW] = b_q[si*DW +: DW];
          end
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_FWD;
        end
      end
      S_FWD: begin
        if (ci < ri) begin
          acc_d = acc_q + AW'(prod);
          col_d = col_q + 1'b1;
        end else begin
          y_d[ri*DW +: DW] = num;
          acc_d = '0;
          if (ri == N-1) begin
            col_d   = RW'(N);
            cnt_d   = '0;
            state_d = S_BWD;
          end else begin
            row_d = row_q + 1'b1;
            col_d = '0;
          end
        end
      end
      S_BWD: begin
        // The first cycle of each row is recognised by col==row+1 with no divide step taken.
        if (ci == ri + 1 && cnt_q == '0 && piv == '0) begin
          x_d     = '0;
          sing_d  = 1'b1;
          state_d = S_DONE;
        end else if (ci < N) begin
          acc_d = acc_q + AW'(prod);
          col_d = col_q + 1'b1;
        end else if (int'(cnt_q) < D) begin
          q_d   = {q_in[QW-2:0], ge};
          r_d   = ge ? DW'(r_sh - {1'b0, dvs_mag}) : r_sh[DW-1:0];
          cnt_d = cnt_q + 1'b1;
        end else begin
          xw_d[ri*DW +: DW] = quo;
          acc_d = '0;
          cnt_d = '0;
          if (ri == 0) begin
            x_d     = xw_d;
            state_d = S_DONE;
          end else begin
            row_d = row_q - 1'b1;
            col_d = row_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lu_q    <= '0;
      p_q     <= '0;
      b_q     <= '0;
      lsing_q <= 1'b0;
      y_q     <= '0;
      xw_q    <= '0;
      x_q     <= '0;
      sing_q  <= 1'b0;
      acc_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
      p_q     <= p_d;
      b_q     <= b_d;
      lsing_q <= lsing_d;
      y_q     <= y_d;
      xw_q    <= xw_d;
      x_q     <= x_d;
      sing_q  <= sing_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      r_q     <= r_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_matlu_solve.sv
// Bench for matlu_solve: one N=3 and one N=2 instance checked against a
// plain-arithmetic reference of forward/back substitution.
module tb_matlu_solve;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matlu_solve_if #(.DATA_WIDTH(32), .MATRIX_SIZE(3)) if3 ();
  matlu_solve_if #(.DATA_WIDTH(32), .MATRIX_SIZE(2)) if2 ();

  matlu_solve #(.DATA_WIDTH(32), .BIN_POS(16), .MATRIX_SIZE(3)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
  matlu_solve #(.DATA_WIDTH(32), .BIN_POS(16), .MATRIX_SIZE(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int total = 0;
  int bad   = 0;

  logic signed [31:0] m_lu [9];
  int unsigned        m_p  [3];
  logic signed [31:0] m_b  [3];
  logic signed [31:0] ex   [3];
  bit                 es;
  int                 elat;
  logic [95:0]        last_x;
  int                 last_lat;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: direct substitution with wide integers and SV signed division.
  task automatic model(input int n, input bit ls);
    logic signed [31:0] y [3];
    logic signed [31:0] xw [3];
    logic signed [65:0] acc;
    logic signed [31:0] num, u;
    longint q;
    for (int i = 0; i < 3; i++) begin ex[i] = '0; xw[i] = '0; y[i] = '0; end
    es = 1'b0;
    elat = 1;
    if (ls) begin es = 1'b1; return; end
    for (int i = 0; i < n; i++) y[i] = (m_p[i] < n) ? m_b[m_p[i]] : m_b[0];
    for (int i = 0; i < n; i++) begin
      acc = '0;
      for (int j = 0; j < i; j++) acc += longint'(m_lu[i*n+j]) * longint'(y[j]);
      y[i] = y[i] - acc[47:16];
      elat += i + 1;
    end
    for (int i = n-1; i >= 0; i--) begin
      u = m_lu[i*n+i];
      elat += 1;
      if (u == 0) begin es = 1'b1; return; end
      elat += (n-1-i) + 48;
      acc = '0;
      for (int j = i+1; j < n; j++) acc += longint'(m_lu[i*n+j]) * longint'(xw[j]);
      num = y[i] - acc[47:16];
      q = (longint'(num) * 64'sd65536) / longint'(u);
      xw[i] = q[31:0];
    end
    for (int i = 0; i < n; i++) ex[i] = xw[i];
  endtask

  function automatic logic [95:0] dut_x(input int n);
    return (n == 3) ? if3.x : {32'b0, if2.x};
  endfunction
  function automatic logic [2:0] dut_flags(input int n);
    return (n == 3) ? {if3.ready, if3.complete, if3.solve_singular}
                    : {if2.ready, if2.complete, if2.solve_singular};
  endfunction

  task automatic drive(input int n, input logic [287:0] luv, input logic [127:0] pv,
                       input logic [95:0] bv, input bit ls, input bit st);
    if (n == 3) begin
      if3.lu = luv; if3.p = pv; if3.b = bv; if3.lu_singular = ls; if3.start = st;
    end else begin
      if2.lu = luv[127:0]; if2.p = pv[95:0]; if2.b = bv[63:0]; if2.lu_singular = ls; if2.start = st;
    end
  endtask

  function automatic logic [287:0] rnd288();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_solve(input int n, input bit ls, input bit poke, input int abort_at);
    logic [287:0] luv;
    logic [127:0] pv;
    logic [95:0]  bv, xb, exv;
    int k;
    bit done;
    model(n, ls);
    luv = '0; pv = '0; bv = '0; exv = '0;
    for (int i = 0; i < n*n; i++) luv[i*32 +: 32] = m_lu[i];
    for (int i = 0; i < n; i++) begin
      pv[i*32 +: 32] = m_p[i];
      bv[i*32 +: 32] = m_b[i];
      exv[i*32 +: 32] = ex[i];
    end
    pv[n*32 +: 32] = $urandom;
    @(negedge clk);
    drive(n, luv, pv, bv, ls, 1'b1);
    xb = dut_x(n);
    @(posedge clk); #1;
    drive(n, rnd288(), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'($urandom), 1'b0);
    chk("accept_flags", dut_flags(n), 3'b000);
    k = 0;
    done = 1'b0;
    while (!done && k < elat + 8) begin
      @(posedge clk); #1;
      k++;
      if (abort_at != 0 && k == abort_at) return;
      if (dut_flags(n) & 3'b010) begin
        chk("latency", k, elat);
        chk("x", dut_x(n), exv);
        chk("done_flags", dut_flags(n), {1'b1, 1'b1, es});
        last_x = dut_x(n);
        last_lat = k;
        done = 1'b1;
      end else begin
        chk("busy_hold", {dut_flags(n), dut_x(n)}, {3'b000, xb});
        if (poke && k == 3) drive(n, luv, pv, {$urandom, $urandom, $urandom}, 1'b0, 1'b1);
        if (poke && k == 4) drive(n, luv, pv, bv, 1'b0, 1'b0);
      end
    end
    chk("complete_seen", done, 1'b1);
  endtask

  function automatic logic signed [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 32'h00080000)) - 32'h00040000;
  endfunction

  task automatic gen_rand(input int n);
    int j;
    int unsigned t;
    for (int k = 0; k < n*n; k++) m_lu[k] = rnd_val();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 11) == 0) m_lu[i*n+i] = '0;
      else if (m_lu[i*n+i] == 0) m_lu[i*n+i] = 32'h00010000;
    end
    for (int i = 0; i < n; i++) m_p[i] = i;
    for (int i = n-1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = m_p[i]; m_p[i] = m_p[j]; m_p[j] = t;
    end
    if ($urandom_range(0, 7) == 0) m_p[$urandom_range(0, n-1)] = n + $urandom_range(0, 1000);
    for (int i = 0; i < n; i++) m_b[i] = rnd_val();
  endtask

  task automatic set_identity3();
    for (int k = 0; k < 9; k++) m_lu[k] = (k % 4 == 0) ? 32'h00010000 : 32'h0;
    m_p[0] = 0; m_p[1] = 1; m_p[2] = 2;
    m_b[0] = 32'h00010000; m_b[1] = 32'h00020000; m_b[2] = 32'hFFFF0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(3, '0, '0, '0, 1'b0, 1'b0);
    drive(2, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("reset_n3", {dut_flags(3), dut_x(3)}, {3'b100, 96'h0});
    chk("reset_n2", {dut_flags(2), dut_x(2)}, {3'b100, 96'h0});
    @(negedge clk);
    rst = 1'b1;

    // Identity, N=3.
    set_identity3();
    model(3, 1'b0);
    chk("pin_id_lat", elat, 157);
    chk("pin_id_x", {ex[2], ex[1], ex[0]}, {32'hFFFF0000, 32'h00020000, 32'h00010000});
    do_solve(3, 1'b0, 1'b0, 0);
    chk("id_x_lit", last_x, {32'hFFFF0000, 32'h00020000, 32'h00010000});
    chk("id_lat_lit", last_lat, 157);

    // Pivoted, N=2: A=[[2,1],[4,3]], b=[3,7].
    m_lu[0] = 32'h00040000; m_lu[1] = 32'h00030000; m_lu[2] = 32'h00008000; m_lu[3] = 32'hFFFF8000;
    m_p[0] = 1; m_p[1] = 0;
    m_b[0] = 32'h00030000; m_b[1] = 32'h00070000;
    model(2, 1'b0);
    chk("pin_piv_lat", elat, 103);
    chk("pin_piv_x", {ex[1], ex[0]}, {32'h00010000, 32'h00010000});
    do_solve(2, 1'b0, 1'b0, 0);
    chk("piv_x_lit", last_x, {32'h0, 32'h00010000, 32'h00010000});
    chk("piv_lat_lit", last_lat, 103);

    // Zero pivot in U[1][1], back-to-back from DONE.
    m_lu[0] = 32'h00020000; m_lu[1] = 32'h00010000; m_lu[2] = 32'h00008000; m_lu[3] = 32'h0;
    m_p[0] = 0; m_p[1] = 1;
    model(2, 1'b0);
    chk("pin_zp", {es, 8'(elat)}, {1'b1, 8'd5});
    do_solve(2, 1'b0, 1'b0, 0);
    chk("zp_x_lit", last_x, 96'h0);

    // Singular flag from matlu, after a good solve so x must clear.
    m_lu[0] = 32'h00040000; m_lu[1] = 32'h00030000; m_lu[2] = 32'h00008000; m_lu[3] = 32'hFFFF8000;
    m_p[0] = 1; m_p[1] = 0;
    do_solve(2, 1'b0, 1'b0, 0);
    model(2, 1'b1);
    chk("pin_ls_lat", elat, 1);
    do_solve(2, 1'b1, 1'b0, 0);
    chk("ls_x_lit", last_x, 96'h0);

    // Start while busy is ignored.
    gen_rand(3);
    for (int k = 0; k < 3; k++) m_lu[k*4] = 32'h00018000;
    do_solve(3, 1'b0, 1'b1, 0);

    for (int t = 0; t < 20; t++) begin
      gen_rand((t % 2 == 0) ? 3 : 2);
      do_solve((t % 2 == 0) ? 3 : 2, ($urandom_range(0, 9) == 0), 1'($urandom), 0);
    end

    // Asynchronous reset in the middle of back substitution.
    set_identity3();
    do_solve(3, 1'b0, 1'b0, 0);
    do_solve(3, 1'b0, 1'b0, 30);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_n3", {dut_flags(3), dut_x(3)}, {3'b100, 96'h0});
    chk("async_rst_n2", {dut_flags(2), dut_x(2)}, {3'b100, 96'h0});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_solve(3, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
